// File: rtl/fifo_pkg.sv
// Shared FIFO types, pointer-width helper and configuration legality check.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit fifo_cfg_ok(input int wd, input int depth, input int af, input int ae);
    return (wd >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_hs_if.sv
// Handshake, data and status bundle between a FIFO and its user.
interface fifo_hs_if #(
  parameter int WD    = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [WD-1:0] i_wr_data;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic [WD-1:0] o_rd_data;
  logic [CW-1:0] o_count;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic          o_overflow;
  logic          o_underflow;

  modport slave (
    input  i_wr_valid, i_wr_data, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_data, o_count,
           o_almost_full, o_almost_empty, o_overflow, o_underflow
  );

  modport master (
    output i_wr_valid, i_wr_data, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_count,
           o_almost_full, o_almost_empty, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WD storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WD    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WD-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WD-1:0] o_rdata
);
  logic [WD-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/fifo_hs.sv
// Single-clock show-ahead FIFO with valid/ready on both sides, occupancy, almost flags, flush.
// Optional sticky overflow/underflow flags when FIFO_ERR_EN is defined (otherwise tied to 0).
module fifo_hs
  import fifo_pkg::*;
#(
  parameter int WD        = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  fifo_hs_if.slave   bus
);
  localparam int AW = fifo_aw(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = (AW+1)'(AE_THRESH);

  if (!fifo_cfg_ok(WD, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
    $error("fifo_hs: illegal WD/DEPTH/threshold configuration");
  end

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         wr_fire, rd_fire;
  fifo_status_t st;

  always_comb begin
    count           = wr_ptr_q - rd_ptr_q;
    st.empty        = (wr_ptr_q == rd_ptr_q);
    st.full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    st.almost_full  = (count >= AF_LVL);
    st.almost_empty = (count <= AE_LVL);
    wr_fire         = bus.i_wr_valid && !st.full;
    rd_fire         = bus.i_rd_ready && !st.empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
`ifdef FIFO_ERR_EN
    ovf_d = ovf_q | (bus.i_wr_valid && st.full);
    unf_d = unf_q | (bus.i_rd_ready && st.empty);
`else
    ovf_d = 1'b0;
    unf_d = 1'b0;
`endif
    // Flush drops this cycle's transfers along with everything stored.
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(.WD(WD), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_fire && !i_rst && !i_flush),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (bus.i_wr_data),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (bus.o_rd_data)
  );

  assign bus.o_wr_ready     = !st.full;
  assign bus.o_rd_valid     = !st.empty;
  assign bus.o_count        = count;
  assign bus.o_almost_full  = st.almost_full;
  assign bus.o_almost_empty = st.almost_empty;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;
endmodule
